// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg: shared types and constants for the TX FIFO pointer controller.
// Used by tx_fifo_ctrl_if, tx_ptr_wrap and tx_fifo_ctrl.
package tx_fifo_pkg;

    localparam int unsigned TX_FIFO_DEPTH = 6;
    localparam int unsigned TX_PTR_W      = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } fifo_state_t;

    // Pointer index plus wrap-toggle bit.
    typedef struct packed {
        logic                tog;
        logic [TX_PTR_W-1:0] idx;
    } ptr_t;

    // Occupancy from head/tail pointers. Modular PTR_W-bit arithmetic is exact
    // because the result never exceeds DEPTH, which fits in PTR_W bits.
    function automatic logic [TX_PTR_W-1:0] occupancy(input ptr_t wr, input ptr_t rd);
        logic [TX_PTR_W-1:0] depth_w;
        depth_w = TX_PTR_W'(TX_FIFO_DEPTH);
        if (wr.tog == rd.tog)
            return wr.idx - rd.idx;
        else
            return depth_w - (rd.idx - wr.idx);
    endfunction

endpackage

// File: rtl/tx_fifo_ctrl_if.sv
// tx_fifo_ctrl_if: handshake and status bundle between the TX FIFO controller
// and its producer/consumer. Optional macro TX_FIFO_WATERMARK_EN adds
// almost_full / almost_empty.
interface tx_fifo_ctrl_if #(
    parameter int unsigned PTR_W = tx_fifo_pkg::TX_PTR_W
);
    logic             enq_req;
    logic             deq_req;
    logic             flush_req;
    logic             enq_ack;
    logic             deq_ack;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic [PTR_W-1:0] count;
    logic             busy;
`ifdef TX_FIFO_WATERMARK_EN
    logic             almost_full;
    logic             almost_empty;
`endif

    // Requesting side (host writer / transmit reader).
    modport master (
        output enq_req, deq_req, flush_req,
        input  enq_ack, deq_ack, wr_ptr, rd_ptr, full, empty, count, busy
`ifdef TX_FIFO_WATERMARK_EN
        , input almost_full, almost_empty
`endif
    );

    // Controller side.
    modport slave (
        input  enq_req, deq_req, flush_req,
        output enq_ack, deq_ack, wr_ptr, rd_ptr, full, empty, count, busy
`ifdef TX_FIFO_WATERMARK_EN
        , output almost_full, almost_empty
`endif
    );

endinterface

// File: rtl/tx_ptr_wrap.sv
// tx_ptr_wrap: modulo-DEPTH pointer with wrap-toggle bit. clr wins over inc.
// Any value >= DEPTH-1 wraps to 0 on increment, so a forced illegal value
// recovers on the next advance.
module tx_ptr_wrap #(
    parameter int unsigned DEPTH = tx_fifo_pkg::TX_FIFO_DEPTH,
    parameter int unsigned PTR_W = tx_fifo_pkg::TX_PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr,
    output logic             tog
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // Pointer/toggle register: clear, or advance with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            tog <= 1'b0;
        end else if (clr) begin
            ptr <= '0;
            tog <= 1'b0;
        end else if (inc) begin
            if (ptr >= LAST) begin
                ptr <= '0;
                tog <= ~tog;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_fifo_ctrl.sv
// tx_fifo_ctrl: head/tail pointer controller and access arbiter for the
// 6-entry TX FIFO. Grants enqueue/dequeue, derives full/empty/count from the
// registered pointers and sequences a one-cycle synchronous flush.
// Optional macro TX_FIFO_WATERMARK_EN adds registered almost_full/almost_empty.
module tx_fifo_ctrl
    import tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = TX_FIFO_DEPTH,
    parameter int unsigned PTR_W = TX_PTR_W
) (
    input  logic               clk,
    input  logic               rst,
    tx_fifo_ctrl_if.slave      bus
);

    fifo_state_t      state;
    fifo_state_t      state_nxt;
    ptr_t             tail;
    ptr_t             head;
    logic             enq_ok;
    logic             deq_ok;
    logic             clr;
    logic             full_r;
    logic             empty_r;
    logic [PTR_W-1:0] cnt;
    logic [PTR_W-1:0] cnt_nxt;

    tx_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (enq_ok),
        .clr (clr),
        .ptr (tail.idx),
        .tog (tail.tog)
    );

    tx_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head (
        .clk (clk),
        .rst (rst),
        .inc (deq_ok),
        .clr (clr),
        .ptr (head.idx),
        .tog (head.tog)
    );

    // Flags, occupancy and grants from registered pointers and state.
    // Grants are also masked by flush_req (flush has priority) and by rst so
    // acks read 0 while reset is held.
    always_comb begin
        empty_r = (tail.idx == head.idx) && (tail.tog == head.tog);
        full_r  = (tail.idx == head.idx) && (tail.tog != head.tog);
        cnt     = occupancy(tail, head);
        clr     = (state == FLUSH);
        enq_ok  = bus.enq_req && !full_r  && (state != FLUSH) && !bus.flush_req && !rst;
        deq_ok  = bus.deq_req && !empty_r && (state != FLUSH) && !bus.flush_req && !rst;
        if (state == FLUSH)
            cnt_nxt = '0;
        else
            cnt_nxt = cnt + PTR_W'(enq_ok) - PTR_W'(deq_ok);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.flush_req)
                    state_nxt = FLUSH;
                else if (enq_ok)
                    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (bus.flush_req)
                    state_nxt = FLUSH;
                else if (cnt_nxt == '0)
                    state_nxt = IDLE;
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Drive the status/handshake outputs.
    always_comb begin
        bus.enq_ack = enq_ok;
        bus.deq_ack = deq_ok;
        bus.wr_ptr  = tail.idx;
        bus.rd_ptr  = head.idx;
        bus.full    = full_r;
        bus.empty   = empty_r;
        bus.count   = cnt;
        bus.busy    = (state == FLUSH);
    end

`ifdef TX_FIFO_WATERMARK_EN
    logic almost_full_r;
    logic almost_empty_r;

    // Watermarks registered from the post-update occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            almost_full_r  <= (cnt_nxt >= PTR_W'(DEPTH - 1));
            almost_empty_r <= (cnt_nxt <= PTR_W'(1));
        end
    end

    // Drive the watermark outputs.
    always_comb begin
        bus.almost_full  = almost_full_r;
        bus.almost_empty = almost_empty_r;
    end
`endif

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// tb_tx_fifo_ctrl: directed self-checking bench for tx_fifo_ctrl.
module tb_tx_fifo_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    tx_fifo_ctrl_if #(.PTR_W(3)) bus ();

    tx_fifo_ctrl #(.DEPTH(6), .PTR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic d, input logic f);
        bus.enq_req   = e;
        bus.deq_req   = d;
        bus.flush_req = f;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.enq_req   = 1'b0;
        bus.deq_req   = 1'b0;
        bus.flush_req = 1'b0;

        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_wr_ptr", 8'(bus.wr_ptr), 8'd0);
        chk("rst_rd_ptr", 8'(bus.rd_ptr), 8'd0);
        chk("rst_empty",  8'(bus.empty),  8'd1);
        chk("rst_full",   8'(bus.full),   8'd0);
        chk("rst_count",  8'(bus.count),  8'd0);
        chk("rst_busy",   8'(bus.busy),   8'd0);
        chk("rst_enq_ack", 8'(bus.enq_ack), 8'd0);
        chk("rst_deq_ack", 8'(bus.deq_ack), 8'd0);
`ifdef TX_FIFO_WATERMARK_EN
        chk("rst_almost_full",  8'(bus.almost_full),  8'd0);
        chk("rst_almost_empty", 8'(bus.almost_empty), 8'd1);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill: six enqueues, wr_ptr 1..5,0
        for (int i = 1; i <= 6; i++) begin
            drive(1, 0, 0);
            chk("fill_enq_ack", 8'(bus.enq_ack), 8'd1);
            tick();
            chk("fill_wr_ptr", 8'(bus.wr_ptr), 8'(i % 6));
            chk("fill_count",  8'(bus.count),  8'(i));
        end
        chk("full_flag",  8'(bus.full),  8'd1);
        chk("full_empty", 8'(bus.empty), 8'd0);
        drive(1, 0, 0);
        chk("enq_when_full", 8'(bus.enq_ack), 8'd0);
        tick();
        chk("full_hold_wr_ptr", 8'(bus.wr_ptr), 8'd0);
        chk("full_hold_count",  8'(bus.count),  8'd6);

        // Full with enq+deq together: only the dequeue is granted
        drive(1, 1, 0);
        chk("full_both_enq_ack", 8'(bus.enq_ack), 8'd0);
        chk("full_both_deq_ack", 8'(bus.deq_ack), 8'd1);
        tick();
        chk("full_both_count",  8'(bus.count),  8'd5);
        chk("full_both_rd_ptr", 8'(bus.rd_ptr), 8'd1);
        chk("full_both_full",   8'(bus.full),   8'd0);

        // Drain the remaining five, rd_ptr 2..5,0
        for (int i = 2; i <= 6; i++) begin
            drive(0, 1, 0);
            chk("drain_deq_ack", 8'(bus.deq_ack), 8'd1);
            tick();
            chk("drain_rd_ptr", 8'(bus.rd_ptr), 8'(i % 6));
            chk("drain_count",  8'(bus.count),  8'(6 - i));
        end
        chk("drained_empty", 8'(bus.empty), 8'd1);
        drive(0, 1, 0);
        chk("deq_when_empty", 8'(bus.deq_ack), 8'd0);
        tick();
        chk("empty_hold_rd_ptr", 8'(bus.rd_ptr), 8'd0);
        chk("empty_busy",        8'(bus.busy),   8'd0);

        // Bring occupancy to 3 (wr_ptr 1,2,3)
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0);
            tick();
            chk("pre3_wr_ptr", 8'(bus.wr_ptr), 8'(i));
        end
        chk("pre3_count", 8'(bus.count), 8'd3);

        // Ten simultaneous enq+deq cycles: count stays 3, both pointers wrap
        for (int k = 1; k <= 10; k++) begin
            drive(1, 1, 0);
            chk("both_enq_ack", 8'(bus.enq_ack), 8'd1);
            chk("both_deq_ack", 8'(bus.deq_ack), 8'd1);
            tick();
            chk("both_count",  8'(bus.count),  8'd3);
            chk("both_wr_ptr", 8'(bus.wr_ptr), 8'((3 + k) % 6));
            chk("both_rd_ptr", 8'(bus.rd_ptr), 8'(k % 6));
        end

        // One more enqueue: count 4, wr_ptr 2
        drive(1, 0, 0);
        tick();
        chk("pre4_count",  8'(bus.count),  8'd4);
        chk("pre4_wr_ptr", 8'(bus.wr_ptr), 8'd2);

        // Flush with a concurrent enqueue request
        drive(1, 0, 1);
        chk("flush_req_enq_ack", 8'(bus.enq_ack), 8'd0);
        chk("flush_req_busy",    8'(bus.busy),    8'd0);
        tick();
        drive(1, 1, 0);
        chk("flush_busy",    8'(bus.busy),    8'd1);
        chk("flush_enq_ack", 8'(bus.enq_ack), 8'd0);
        chk("flush_deq_ack", 8'(bus.deq_ack), 8'd0);
        tick();
        drive(0, 0, 0);
        chk("post_flush_busy",   8'(bus.busy),   8'd0);
        chk("post_flush_wr_ptr", 8'(bus.wr_ptr), 8'd0);
        chk("post_flush_rd_ptr", 8'(bus.rd_ptr), 8'd0);
        chk("post_flush_empty",  8'(bus.empty),  8'd1);
        chk("post_flush_count",  8'(bus.count),  8'd0);

        // flush_req held: FLUSH, IDLE, FLUSH
        drive(0, 0, 1);
        tick();
        chk("hold_flush_busy1", 8'(bus.busy), 8'd1);
        tick();
        chk("hold_flush_busy2", 8'(bus.busy), 8'd0);
        tick();
        chk("hold_flush_busy3", 8'(bus.busy), 8'd1);
        drive(0, 0, 0);
        tick();
        chk("hold_flush_busy4", 8'(bus.busy),  8'd0);
        chk("hold_flush_empty", 8'(bus.empty), 8'd1);

        // Asynchronous reset mid-transfer
        drive(1, 0, 0);
        tick();
        tick();
        chk("mid_xfer_count", 8'(bus.count), 8'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_xfer_count",   8'(bus.count),   8'd0);
        chk("async_xfer_wr_ptr",  8'(bus.wr_ptr),  8'd0);
        chk("async_xfer_empty",   8'(bus.empty),   8'd1);
        chk("async_xfer_enq_ack", 8'(bus.enq_ack), 8'd0);
        bus.enq_req = 1'b0;
        rst = 1'b0;
        tick();

        // Asynchronous reset mid-FLUSH
        drive(1, 0, 0);
        tick();
        drive(0, 0, 1);
        tick();
        chk("mid_flush_busy", 8'(bus.busy), 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_flush_busy",   8'(bus.busy),   8'd0);
        chk("async_flush_count",  8'(bus.count),  8'd0);
        chk("async_flush_wr_ptr", 8'(bus.wr_ptr), 8'd0);
        chk("async_flush_empty",  8'(bus.empty),  8'd1);
        bus.flush_req = 1'b0;
        rst = 1'b0;
        tick();

`ifdef TX_FIFO_WATERMARK_EN
        // Watermarks: almost_empty up to count 1, almost_full from count 5
        for (int i = 1; i <= 6; i++) begin
            drive(1, 0, 0);
            tick();
            chk("wm_almost_empty", 8'(bus.almost_empty), 8'(i <= 1));
            chk("wm_almost_full",  8'(bus.almost_full),  8'(i >= 5));
        end
        drive(0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_fifo_ctrl.md
Name: tx_fifo_ctrl

Overview:
Pointer controller and access arbiter for the 6-entry TX FIFO. Owns the head (read) and tail (write) pointers, each with a wrap-toggle bit. Grants producer enqueues and consumer dequeues, derives full/empty/count, and sequences a synchronous flush. Sits between the TX FIFO register file and the host-side writer / transmit-side reader.

Parameters:
DEPTH, 6, number of FIFO entries; pointers wrap from DEPTH-1 to 0.
PTR_W, 3, pointer width; must satisfy 2**PTR_W >= DEPTH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
enq_req  in  1  producer requests a write this cycle.
deq_req  in  1  consumer requests a read this cycle.
flush_req  in  1  request to empty the FIFO.
enq_ack  out  1  write granted this cycle (combinational).
deq_ack  out  1  read granted this cycle (combinational).
wr_ptr  out  PTR_W  register-file write index (tail).
rd_ptr  out  PTR_W  register-file read index (head).
full  out  1  registered-state full flag.
empty  out  1  registered-state empty flag.
count  out  PTR_W  current occupancy, 0..DEPTH.
busy  out  1  high while in FLUSH.

Behaviour:
- Reset (rst=1, async): wr_ptr=0, rd_ptr=0, both toggles=0, state=IDLE. Outputs: empty=1, full=0, count=0, busy=0, acks=0.
- Flags, from registered pointers only:
  - empty = (wr_ptr==rd_ptr) && (wr_tog==rd_tog).
  - full = (wr_ptr==rd_ptr) && (wr_tog!=rd_tog).
  - count = wr_ptr-rd_ptr when toggles are equal, else DEPTH-(rd_ptr-wr_ptr); result always in 0..DEPTH.
- Grants:
  - enq_ack = enq_req && !full && state!=FLUSH.
  - deq_ack = deq_req && !empty && state!=FLUSH.
  - Enqueue when full is refused even if a dequeue happens the same cycle; no pass-through.
  - Simultaneous enq_ack and deq_ack are legal: both pointers advance and count is unchanged.
- Pointer advance, at the next clk edge:
  - On enq_ack, wr_ptr increments. At DEPTH-1 it wraps to 0 and wr_tog inverts.
  - rd_ptr and rd_tog behave the same way on deq_ack.
- Data timing: the register file writes at wr_ptr on the enq_ack edge. Read data at rd_ptr is valid in the deq_ack cycle, with zero added latency.
- FSM:
  - IDLE: empty FIFO. Goes to ACTIVE on enq_ack. Goes to FLUSH on flush_req.
  - ACTIVE: goes to IDLE when the next state is empty (count reaches 0 after update). Goes to FLUSH on flush_req.
  - FLUSH: busy=1 and all grants suppressed for exactly one cycle. Both pointers and toggles clear to 0, then the FSM returns to IDLE.
  - flush_req has priority over enq_req and deq_req in the same cycle; requests in that cycle are not acked.
  - flush_req held high re-enters FLUSH every other cycle (FLUSH→IDLE→FLUSH).
- Reset mid-operation (including mid-FLUSH) returns immediately to the reset values above.
- Illegal pointer values (>= DEPTH) are unreachable. If forced, the next increment wraps to 0 and toggles the wrap bit.

Optional Feature:
- Macro: TX_FIFO_WATERMARK_EN.
- Defined: adds output almost_full (1 bit), registered, set when the next-state count >= DEPTH-1. Also adds output almost_empty, set when the next-state count <= 1. Both reset to almost_full=0, almost_empty=1.
- Undefined: neither port exists and there is no extra logic.

Decomposition:
- Package tx_fifo_pkg holds:
  - the FSM state enum (IDLE, ACTIVE, FLUSH);
  - constants TX_FIFO_DEPTH=6 and TX_PTR_W=3;
  - a ptr_t typedef (PTR_W pointer plus toggle bit).
- Sub-module tx_ptr_wrap is natural. It is a wrap counter with toggle, with inputs clk, rst, inc, clr and outputs ptr, tog. It is instantiated twice, once for head and once for tail.

Test Plan:
- Reset, then 6 enqueues with no dequeues → enq_ack high on all 6; wr_ptr goes 1..5,0; wr_tog=1; full=1; count=6; a 7th enq_req gets enq_ack=0.
- From full, 6 dequeues → rd_ptr goes 1..5,0; rd_tog=1; empty=1; count=0; FSM back to IDLE; a 7th deq_req gets deq_ack=0.
- With count=3, enq_req and deq_req together for 10 cycles → both acked every cycle; count stays 3; pointers wrap with their toggles flipping together.
- Full, with enq_req and deq_req in the same cycle → deq_ack=1, enq_ack=0; count becomes 5 on the next cycle.
- With count=4, assert flush_req together with enq_req → no acks; busy=1 for one cycle; then wr_ptr=rd_ptr=0, empty=1, state IDLE.
- Assert rst asynchronously mid-FLUSH and mid-transfer → outputs return to reset values without waiting for a clock edge; with TX_FIFO_WATERMARK_EN, almost_full asserts at count 5 and almost_empty at count 1.
